// File: rtl/pwm_multi_channel_pkg.sv
// pwm_multi_channel_pkg: shared handshake state encoding and channel-select width helper
package pwm_multi_channel_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_ACK_HI = 1'b1} hs_state_t;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: four-phase req/ack duty write bus
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 2,
  parameter int DUTY_WIDTH = 12
);
  import pwm_multi_channel_pkg::*;
  localparam int SEL_W = sel_w(CHANNELS);
  logic req;
  logic [SEL_W-1:0] chan_sel;
  logic [DUTY_WIDTH-1:0] duty_cycle;
  logic ack;
  modport master (output req, chan_sel, duty_cycle, input ack);
  modport slave (input req, chan_sel, duty_cycle, output ack);
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/active duty pair with wrap-synchronous commit and registered comparator
module pwm_channel #(
  parameter int DUTY_WIDTH = 12,
  parameter logic [DUTY_WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [DUTY_WIDTH-1:0] i_wr_duty,
  input  logic                  i_commit,
  input  logic [DUTY_WIDTH-1:0] i_cnt,
  input  logic                  i_en,
  output logic                  o_pwm,
  output logic [DUTY_WIDTH-1:0] o_active_duty
);
  logic [DUTY_WIDTH-1:0] r_shadow, r_active;
  logic r_pending, r_pwm;
  // A capture coinciding with a commit keeps its pending flag, so the old shadow lands now and the new one next wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= RESET_DUTY;
      r_active  <= RESET_DUTY;
      r_pending <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      if (i_wr) r_shadow <= i_wr_duty;
      if (!i_en || (i_commit && r_pending)) r_active <= r_shadow;
      r_pending <= i_wr | (r_pending & i_en & ~i_commit);
      r_pwm     <= i_en & (i_cnt < r_active);
    end
  end
  assign o_pwm = r_pwm;
  assign o_active_duty = r_active;
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM with shared period counter and handshake-loaded duties
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DUTY_WIDTH = 12,
  parameter logic [DUTY_WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  pwm_multi_channel_if.slave             bus,
  output logic                           o_period_wrap,
  output logic [CHANNELS-1:0]            o_pwm_out,
  output logic [CHANNELS*DUTY_WIDTH-1:0] o_pwm_duty_cycle
);
  localparam int SEL_W = sel_w(CHANNELS);
  hs_state_t r_state;
  logic [DUTY_WIDTH-1:0] r_cnt;
  logic r_ack, w_wrap, w_cap;
  assign w_wrap = i_en && (r_cnt == '1);
  assign w_cap = (r_state == S_IDLE) && bus.req;
  assign o_period_wrap = w_wrap;
  assign bus.ack = r_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_cnt <= i_en ? r_cnt + 1'b1 : '0;
      if (w_cap) begin
        r_state <= S_ACK_HI;
        r_ack   <= 1'b1;
      end else if (r_state == S_ACK_HI && !bus.req) begin
        r_state <= S_IDLE;
        r_ack   <= 1'b0;
      end
    end
  end
  // Out-of-range chan_sel matches no channel, so the write is acked but dropped
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH), .RESET_DUTY(RESET_DUTY)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_wr         (w_cap && (bus.chan_sel == SEL_W'(g))),
      .i_wr_duty    (bus.duty_cycle),
      .i_commit     (w_wrap),
      .i_cnt        (r_cnt),
      .i_en         (i_en),
      .o_pwm        (o_pwm_out[g]),
      .o_active_duty(o_pwm_duty_cycle[g*DUTY_WIDTH +: DUTY_WIDTH])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed scoreboard bench for a 2-channel and a 3-channel 4-bit PWM
module tb_pwm_multi_channel;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, en_a, en_b;
  always #5 clk = ~clk;
  pwm_multi_channel_if #(.CHANNELS(2), .DUTY_WIDTH(W)) bus_a ();
  pwm_multi_channel_if #(.CHANNELS(3), .DUTY_WIDTH(W)) bus_b ();
  logic wrap_a, wrap_b;
  logic [1:0] pwm_a;
  logic [2:0] pwm_b;
  logic [7:0] duty_a;
  logic [11:0] duty_b;
  pwm_multi_channel #(.CHANNELS(2), .DUTY_WIDTH(W), .RESET_DUTY(4'd0)) dut_a (
    .clk(clk), .rst(rst), .i_en(en_a), .bus(bus_a),
    .o_period_wrap(wrap_a), .o_pwm_out(pwm_a), .o_pwm_duty_cycle(duty_a)
  );
  pwm_multi_channel #(.CHANNELS(3), .DUTY_WIDTH(W), .RESET_DUTY(4'd0)) dut_b (
    .clk(clk), .rst(rst), .i_en(en_b), .bus(bus_b),
    .o_period_wrap(wrap_b), .o_pwm_out(pwm_b), .o_pwm_duty_cycle(duty_b)
  );
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  task automatic push(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=entry", obs);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_a(input logic ch, input logic [3:0] d);
    bus_a.req = 1'b1; bus_a.chan_sel = ch; bus_a.duty_cycle = d;
    push("ack_a_rise", 1);
    tick();
    pop_chk(bus_a.ack);
    bus_a.req = 1'b0;
    push("ack_a_fall", 0);
    tick();
    pop_chk(bus_a.ack);
  endtask
  task automatic wr_b(input logic [1:0] ch, input logic [3:0] d);
    bus_b.req = 1'b1; bus_b.chan_sel = ch; bus_b.duty_cycle = d;
    push("ack_b_rise", 1);
    tick();
    pop_chk(bus_b.ack);
    bus_b.req = 1'b0;
    push("ack_b_fall", 0);
    tick();
    pop_chk(bus_b.ack);
  endtask
  task automatic sync_wrap(input bit chk_pwm, input logic [1:0] exp_pwm);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (chk_pwm) push("pwm_hold", exp_pwm);
      tick();
      if (chk_pwm) pop_chk(pwm_a);
      found = wrap_a;
    end
    push("wrap_seen", 1);
    pop_chk(found);
  endtask
  // Starts on a wrap sample; sample 1 still reflects cnt=15 against the outgoing duties
  task automatic check_period(input logic [3:0] o0, o1, n0, n1, input bit wr, input logic [3:0] wd);
    if (wr) begin
      bus_a.req = 1'b1; bus_a.chan_sel = 1'b0; bus_a.duty_cycle = wd;
    end
    for (int j = 1; j <= 16; j++) begin
      logic [3:0] c;
      c = 4'(j - 2);
      push("pwm_a", (j == 1) ? {4'd15 < o1, 4'd15 < o0} : {c < n1, c < n0});
      push("wrap_a", j == 16);
      if (wr && j <= 2) push("ack_a_wrap", j == 1);
      tick();
      pop_chk(pwm_a);
      pop_chk(wrap_a);
      if (wr && j <= 2) pop_chk(bus_a.ack);
      if (wr && j == 1) bus_a.req = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    bus_a.req = 1'b0; bus_a.chan_sel = '0; bus_a.duty_cycle = '0;
    bus_b.req = 1'b0; bus_b.chan_sel = '0; bus_b.duty_cycle = '0;
    tick();
    tick();
    push("rst_ack", 0); push("rst_pwm", 0); push("rst_duty", 0); push("rst_wrap", 0); push("rst_duty_b", 0);
    pop_chk(bus_a.ack); pop_chk(pwm_a); pop_chk(duty_a); pop_chk(wrap_a); pop_chk(duty_b);
    rst = 1'b0;
    // idle periods with no writes
    en_a = 1'b1;
    sync_wrap(1'b1, 2'b00);
    check_period(0, 0, 0, 0, 1'b0, 0);
    check_period(0, 0, 0, 0, 1'b0, 0);
    // mid-period write of ch0=4 waits for the wrap
    for (int i = 0; i < 5; i++) tick();
    wr_a(1'b0, 4'd4);
    push("duty_pre_commit", 8'h00);
    pop_chk(duty_a);
    sync_wrap(1'b1, 2'b00);
    check_period(0, 0, 4, 0, 1'b0, 0);
    push("duty_ch0_4", 8'h04);
    pop_chk(duty_a);
    check_period(4, 0, 4, 0, 1'b0, 0);
    // extremes: ch1=15, ch0=0
    for (int i = 0; i < 3; i++) tick();
    wr_a(1'b1, 4'd15);
    wr_a(1'b0, 4'd0);
    sync_wrap(1'b0, 2'b00);
    check_period(4, 0, 0, 15, 1'b0, 0);
    push("duty_f0", 8'hF0);
    pop_chk(duty_a);
    check_period(0, 15, 0, 15, 1'b0, 0);
    // capture on the wrap cycle: pending 4 commits, 9 waits one more period
    for (int i = 0; i < 3; i++) tick();
    wr_a(1'b0, 4'd4);
    sync_wrap(1'b0, 2'b00);
    check_period(0, 15, 4, 15, 1'b1, 4'd9);
    check_period(4, 15, 9, 15, 1'b0, 0);
    push("duty_9f", 8'hF9);
    pop_chk(duty_a);
    // long req: single capture, later bus changes ignored
    en_a = 1'b0;
    tick();
    tick();
    bus_a.req = 1'b1; bus_a.chan_sel = 1'b1; bus_a.duty_cycle = 4'd3;
    push("ack_hold0", 1);
    tick();
    pop_chk(bus_a.ack);
    bus_a.chan_sel = 1'b0; bus_a.duty_cycle = 4'd7;
    for (int i = 0; i < 4; i++) begin
      push("ack_hold", 1);
      tick();
      pop_chk(bus_a.ack);
    end
    bus_a.req = 1'b0;
    push("ack_hold_fall", 0);
    tick();
    pop_chk(bus_a.ack);
    tick();
    push("duty_hold", 8'h39); push("pwm_en0", 0); push("wrap_en0", 0);
    pop_chk(duty_a); pop_chk(pwm_a); pop_chk(wrap_a);
    // three-channel instance: valid write then out-of-range select
    wr_b(2'd2, 4'd5);
    push("duty_b_ch2", 12'h500);
    pop_chk(duty_b);
    wr_b(2'd3, 4'hA);
    tick();
    push("duty_b_sel3", 12'h500);
    pop_chk(duty_b);
    // reset in the middle of a handshake with a pending write
    en_a = 1'b1;
    push("pwm_en1", 2'b11);
    tick();
    pop_chk(pwm_a);
    bus_a.req = 1'b1; bus_a.chan_sel = 1'b0; bus_a.duty_cycle = 4'd6;
    push("ack_pre_rst", 1);
    tick();
    pop_chk(bus_a.ack);
    rst = 1'b1; bus_a.req = 1'b0;
    push("rst_mid_ack", 0); push("rst_mid_pwm", 0); push("rst_mid_duty", 0);
    tick();
    pop_chk(bus_a.ack); pop_chk(pwm_a); pop_chk(duty_a);
    rst = 1'b0; en_a = 1'b0;
    tick();
    tick();
    push("duty_no_pending", 0);
    pop_chk(duty_a);
    bus_a.req = 1'b1; bus_a.chan_sel = 1'b0; bus_a.duty_cycle = 4'd7;
    push("ack_en0", 1); push("duty_en0_cap", 0);
    tick();
    pop_chk(bus_a.ack); pop_chk(duty_a);
    bus_a.req = 1'b0;
    push("ack_en0_fall", 0); push("duty_en0_next", 8'h07);
    tick();
    pop_chk(bus_a.ack); pop_chk(duty_a);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
